// File: rtl/rv32_fp_register_file_sb_if.sv
// Bus bundle for the FP register file: read ports, write ports, scoreboard issue and FS dirty control.
interface rv32_fp_register_file_sb_if #(
    parameter int unsigned FLEN   = 32,
    parameter int unsigned NUM_RD = 3,
    parameter int unsigned NUM_WR = 2
);
    logic [NUM_RD*5-1:0]    raddr_i;
    logic [NUM_RD*FLEN-1:0] rdata_o;
    logic [NUM_RD-1:0]      rbusy_o;
    logic [NUM_WR-1:0]      we_i;
    logic [NUM_WR*5-1:0]    waddr_i;
    logic [NUM_WR*FLEN-1:0] wdata_i;
    logic [NUM_WR-1:0]      wclr_i;
    logic                   issue_i;
    logic [4:0]             issue_rd_i;
    logic                   issue_ready_o;
    logic                   dirty_o;
    logic                   dirty_clr_i;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, wclr_i, issue_i, issue_rd_i, dirty_clr_i,
        input  rdata_o, rbusy_o, issue_ready_o, dirty_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, wclr_i, issue_i, issue_rd_i, dirty_clr_i,
        output rdata_o, rbusy_o, issue_ready_o, dirty_o
    );
endinterface

// File: rtl/rv32_fp_register_file_sb.sv
// 32 x FLEN FP register file with busy scoreboard and sticky FS-dirty flag.
// Optional same-cycle write forwarding on reads: define FP_RF_BYPASS_EN.
module rv32_fp_register_file_sb #(
    parameter int unsigned FLEN   = 32,
    parameter int unsigned NUM_RD = 3,
    parameter int unsigned NUM_WR = 2
) (
    input logic clk_i,
    input logic rst_i,
    rv32_fp_register_file_sb_if.slave bus
);
    logic [FLEN-1:0]        rf_q [32];
    logic [31:0]            busy_q, busy_d;
    logic                   dirty_q, dirty_d;
    logic [NUM_RD*FLEN-1:0] rdata;
    logic [NUM_RD-1:0]      rbusy;

    // Clears are applied first so a same-cycle issue to the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (bus.we_i[w] && bus.wclr_i[w]) begin
                busy_d[bus.waddr_i[w*5 +: 5]] = 1'b0;
            end
        end
        if (bus.issue_i) begin
            busy_d[bus.issue_rd_i] = 1'b1;
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (|bus.we_i) begin
            dirty_d = 1'b1;
        end else if (bus.dirty_clr_i) begin
            dirty_d = 1'b0;
        end
    end

    // Higher-numbered write ports are applied later, so port 1 wins an address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < 32; r++) begin
                rf_q[r] <= '0;
            end
            busy_q  <= '0;
            dirty_q <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (bus.we_i[w]) begin
                    rf_q[bus.waddr_i[w*5 +: 5]] <= bus.wdata_i[w*FLEN +: FLEN];
                end
            end
            busy_q  <= busy_d;
            dirty_q <= dirty_d;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rdata[k*FLEN +: FLEN] = rf_q[bus.raddr_i[k*5 +: 5]];
            rbusy[k]              = busy_q[bus.raddr_i[k*5 +: 5]];
`ifdef FP_RF_BYPASS_EN
            if (!rst_i) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (bus.we_i[w] && (bus.waddr_i[w*5 +: 5] == bus.raddr_i[k*5 +: 5])) begin
                        rdata[k*FLEN +: FLEN] = bus.wdata_i[w*FLEN +: FLEN];
                    end
                end
            end
`else
            // No forwarding: a same-cycle read sees the array contents only.
`endif
        end
    end

    assign bus.rdata_o       = rdata;
    assign bus.rbusy_o       = rbusy;
    assign bus.issue_ready_o = ~busy_q[bus.issue_rd_i];
    assign bus.dirty_o       = dirty_q;
endmodule

// File: tb/tb_rv32_fp_register_file_sb.sv
// Scoreboard bench for rv32_fp_register_file_sb (default parameters, FLEN=32).
module tb_rv32_fp_register_file_sb;
    localparam int unsigned FLEN   = 32;
    localparam int unsigned NUM_RD = 3;
    localparam int unsigned NUM_WR = 2;

    localparam int K_RD    = 0;
    localparam int K_BUSY  = 1;
    localparam int K_READY = 2;
    localparam int K_DIRTY = 3;

    typedef struct {
        int          kind;
        int          port;
        logic [4:0]  addr;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [31:0] mdl [32];
    logic [31:0] mbusy;
    logic        mdirty;

    rv32_fp_register_file_sb_if #(.FLEN(FLEN), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    rv32_fp_register_file_sb #(.FLEN(FLEN), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int port, input logic [4:0] addr,
                        input logic [63:0] exp, input string tag);
        exp_t e;
        e.kind = kind; e.port = port; e.addr = addr; e.exp = exp; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_rd(input int port, input logic [4:0] addr, input string tag);
        push(K_RD, port, addr, {32'h0, mdl[addr]}, tag);
    endtask

    // Drive one cycle of stimulus and advance the reference model to its post-edge state.
    task automatic drive(input logic r, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [1:0] wclr, input logic iss, input logic [4:0] ird,
                         input logic dclr);
        rst             = r;
        bus.we_i        = we;
        bus.waddr_i     = {wa1, wa0};
        bus.wdata_i     = {wd1, wd0};
        bus.wclr_i      = wclr;
        bus.issue_i     = iss;
        bus.issue_rd_i  = ird;
        bus.dirty_clr_i = dclr;
        if (r) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
            mbusy  = '0;
            mdirty = 1'b0;
        end else begin
            if (we[0]) mdl[wa0] = wd0;
            if (we[1]) mdl[wa1] = wd1;
            if (we[0] && wclr[0]) mbusy[wa0] = 1'b0;
            if (we[1] && wclr[1]) mbusy[wa1] = 1'b0;
            if (iss) mbusy[ird] = 1'b1;
            if (we != 2'b00) mdirty = 1'b1;
            else if (dclr) mdirty = 1'b0;
        end
    endtask

    task automatic tick_and_drain();
        exp_t e;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.we_i        = '0;
        bus.wclr_i      = '0;
        bus.issue_i     = 1'b0;
        bus.dirty_clr_i = 1'b0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD: begin
                    bus.raddr_i[e.port*5 +: 5] = e.addr;
                    #1;
                    check_eq(e.tag, {32'h0, bus.rdata_o[e.port*FLEN +: FLEN]}, e.exp);
                end
                K_BUSY: begin
                    bus.raddr_i[e.port*5 +: 5] = e.addr;
                    #1;
                    check_eq(e.tag, {63'h0, bus.rbusy_o[e.port]}, e.exp);
                end
                K_READY: begin
                    bus.issue_rd_i = e.addr;
                    #1;
                    check_eq(e.tag, {63'h0, bus.issue_ready_o}, e.exp);
                end
                default: begin
                    #1;
                    check_eq(e.tag, {63'h0, bus.dirty_o}, e.exp);
                end
            endcase
        end
    endtask

    initial begin
        bus.raddr_i = '0; bus.we_i = '0; bus.waddr_i = '0; bus.wdata_i = '0;
        bus.wclr_i = '0; bus.issue_i = 1'b0; bus.issue_rd_i = '0; bus.dirty_clr_i = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mbusy = '0; mdirty = 1'b0;

        // 1. random writes and issues, then two reset cycles
        drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
        tick_and_drain();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 2'b11, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
                  $urandom, 2'b00, 1'b1, 5'($urandom_range(0, 31)), 1'b0);
            tick_and_drain();
        end
        drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
        tick_and_drain();
        drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
        for (int r = 0; r < 32; r++) begin
            push(K_RD, r % 3, 5'(r), 64'h0, "rst_rdata");
            push(K_BUSY, (r + 1) % 3, 5'(r), 64'h0, "rst_rbusy");
        end
        push(K_READY, 0, 5'd3, 64'h1, "rst_ready");
        push(K_DIRTY, 0, 5'd0, 64'h0, "rst_dirty");
        tick_and_drain();

        // 2. write f5 via port 0; same-cycle read first, then next-cycle read
        drive(1'b0, 2'b01, 5'd5, 32'h3F800000, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
        bus.raddr_i[4:0] = 5'd5;
        #1;
`ifdef FP_RF_BYPASS_EN
        check_eq("same_cycle_rd", {32'h0, bus.rdata_o[31:0]}, 64'h3F800000);
`else
        check_eq("same_cycle_rd", {32'h0, bus.rdata_o[31:0]}, 64'h0);
`endif
        push(K_RD, 0, 5'd5, 64'h3F800000, "wr_rd_f5");
        push(K_DIRTY, 0, 5'd0, 64'h1, "wr_dirty");
        tick_and_drain();

        // 3. collision on f7
        drive(1'b0, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b00, 1'b0, 5'd0, 1'b0);
        push(K_RD, 1, 5'd7, 64'h22222222, "collision_f7");
        tick_and_drain();

        // 4. scoreboard set, clear, set-wins
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b1, 5'd9, 1'b0);
        push(K_BUSY, 2, 5'd9, 64'h1, "sb_busy_f9");
        push(K_READY, 0, 5'd9, 64'h0, "sb_ready_f9");
        push(K_READY, 0, 5'd10, 64'h1, "sb_ready_f10");
        tick_and_drain();
        drive(1'b0, 2'b10, 5'd0, 32'h0, 5'd9, 32'h40490FDB, 2'b10, 1'b0, 5'd0, 1'b0);
        push(K_BUSY, 0, 5'd9, 64'h0, "sb_clr_f9");
        push(K_RD, 2, 5'd9, 64'h40490FDB, "sb_data_f9");
        tick_and_drain();
        drive(1'b0, 2'b10, 5'd0, 32'h0, 5'd9, 32'hC0000000, 2'b10, 1'b1, 5'd9, 1'b0);
        push(K_BUSY, 1, 5'd9, 64'h1, "sb_setwins_f9");
        push(K_READY, 0, 5'd9, 64'h0, "sb_setwins_ready");
        tick_and_drain();

        // 5. dirty priority
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
        push(K_DIRTY, 0, 5'd0, 64'h0, "dirty_clr");
        tick_and_drain();
        drive(1'b0, 2'b01, 5'd3, 32'h0BADF00D, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
        push(K_DIRTY, 0, 5'd0, 64'h1, "dirty_wr_wins");
        tick_and_drain();

        // 6. reset mid-operation with f12 busy and written
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b1, 5'd12, 1'b0);
        push(K_BUSY, 0, 5'd12, 64'h1, "mid_busy_f12");
        tick_and_drain();
        drive(1'b1, 2'b01, 5'd12, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01, 1'b1, 5'd13, 1'b0);
        push(K_RD, 0, 5'd12, 64'h0, "mid_rst_f12");
        push(K_BUSY, 1, 5'd12, 64'h0, "mid_rst_busy12");
        push(K_BUSY, 2, 5'd13, 64'h0, "mid_rst_busy13");
        tick_and_drain();
        drive(1'b0, 2'b10, 5'd0, 32'h0, 5'd12, 32'h3F000000, 2'b10, 1'b0, 5'd0, 1'b0);
        push(K_RD, 0, 5'd12, 64'h3F000000, "late_wr_f12");
        push(K_BUSY, 0, 5'd12, 64'h0, "late_clr_busy12");
        tick_and_drain();

        // random traffic checked against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [4:0] a0, a1, ir, rr;
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            ir = 5'($urandom_range(0, 7));
            rr = 5'($urandom_range(0, 31));
            drive(1'b0, 2'($urandom), a0, $urandom, a1, $urandom, 2'($urandom),
                  1'($urandom), ir, 1'($urandom));
            push_rd(0, a0, "rnd_rd_a0");
            push_rd(1, a1, "rnd_rd_a1");
            push_rd(2, rr, "rnd_rd_r");
            push(K_BUSY, 0, a0, {63'h0, mbusy[a0]}, "rnd_busy_a0");
            push(K_BUSY, 1, a1, {63'h0, mbusy[a1]}, "rnd_busy_a1");
            push(K_READY, 0, ir, {63'h0, ~mbusy[ir]}, "rnd_ready");
            push(K_DIRTY, 0, 5'd0, {63'h0, mdirty}, "rnd_dirty");
            tick_and_drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
